sseg_scan_mux: RTL and testbench

Parametrised, time-multiplexed seven-segment digit scanner. It is the clocked successor to the team's combinational 4-to-1 BCD digit mux. It owns its own refresh prescaler and one-hot digit rotation, and holds a tear-free frame buffer of the digit values. It also adds per-digit blanking, decimal points and leading-zero suppression. It sits between the BCD/binary value logic and the BCD-to-segment decoder plus the board anode pins.

---
 rtl/sseg_scan_mux.sv | 90 +++++++++
 tb/tb_sseg_scan_mux.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed seven-segment digit scanner with a tear-free frame
// buffer, per-digit blanking, decimal points and leading-zero blanking.
module sseg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    localparam int IDX_W      = $clog2(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lzb_en,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [3:0]              bcd_seg,
    output logic                    dp_o,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_dig;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic                    r_tick;

    logic                    w_step;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_zero_up;
    logic [NUM_DIGITS-1:0]   w_dark;
    logic [3:0]              w_sel;
    logic                    w_lit;

    assign w_step = en && (r_cnt == CNT_LAST);
    assign w_wrap = w_step && (r_idx == IDX_LAST);

    // Shadow only refreshes at a frame boundary or while the display is off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dig   <= '0;
            r_dp    <= '0;
            r_blank <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (en) begin
                if (w_step) begin
                    r_cnt <= '0;
                    r_idx <= w_wrap ? '0 : r_idx + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (!en || w_wrap) begin
                r_dig   <= digits_in;
                r_dp    <= dp_in;
                r_blank <= blank_in;
            end
        end
    end

    // Bit k set when shadow digits k..NUM_DIGITS-1 are all zero.
    always_comb begin
        w_zero_up = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_zero_up[k] = ((r_dig >> (4 * k)) == '0);
        end
    end

    assign w_dark = r_blank
                  | (w_zero_up & ~NUM_DIGITS'(1) & {NUM_DIGITS{lzb_en}});

    assign w_sel = r_dig[{r_idx, 2'b00} +: 4];
    assign w_lit = en && !rst && !w_dark[r_idx];

    assign anode_n    = w_lit ? ~(NUM_DIGITS'(1) << r_idx) : '1;
    assign bcd_seg    = w_lit ? w_sel : 4'hF;
    assign dp_o       = w_lit && r_dp[r_idx];
    assign digit_idx  = r_idx;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Bench for sseg_scan_mux: a 4-digit/div-4 and an 8-digit/div-1 instance
// share inputs; directed tables, sequences and a reference model.
module tb_sseg_scan_mux;

    logic        clk = 1'b0;
    logic        rst, en, lzb;
    logic [31:0] digits;
    logic [7:0]  dpv, blv;

    logic [3:0]  a_an, a_bcd;
    logic        a_dp, a_tick;
    logic [1:0]  a_idx;
    logic [7:0]  b_an;
    logic [3:0]  b_bcd;
    logic        b_dp, b_tick;
    logic [2:0]  b_idx;

    int checks = 0;
    int errors = 0;
    bit mchk = 1'b0;

    longint      ecnt[2];
    logic [31:0] sh_d[2];
    logic [7:0]  sh_dp[2];
    logic [7:0]  sh_bl[2];
    logic        mtick[2];

    always #5 clk = ~clk;

    sseg_scan_mux #(.NUM_DIGITS(4), .REFRESH_DIV(4)) u_a (
        .clk(clk), .rst(rst), .en(en),
        .digits_in(digits[15:0]), .dp_in(dpv[3:0]), .blank_in(blv[3:0]),
        .lzb_en(lzb), .anode_n(a_an), .bcd_seg(a_bcd), .dp_o(a_dp),
        .digit_idx(a_idx), .frame_tick(a_tick)
    );

    sseg_scan_mux #(.NUM_DIGITS(8), .REFRESH_DIV(1)) u_b (
        .clk(clk), .rst(rst), .en(en),
        .digits_in(digits), .dp_in(dpv), .blank_in(blv),
        .lzb_en(lzb), .anode_n(b_an), .bcd_seg(b_bcd), .dp_o(b_dp),
        .digit_idx(b_idx), .frame_tick(b_tick)
    );

    function automatic int nd(input int u);
        return (u == 1) ? 8 : 4;
    endfunction

    function automatic int dv(input int u);
        return (u == 1) ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: idx follows from the number of enabled cycles since reset.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                ecnt[u]  = 0;
                sh_d[u]  = '0;
                sh_dp[u] = '0;
                sh_bl[u] = '0;
                mtick[u] = 1'b0;
            end else begin
                bit wrap;
                wrap = en && (((ecnt[u] + 1) % longint'(nd(u) * dv(u))) == 0);
                mtick[u] = wrap;
                if (en) ecnt[u] = ecnt[u] + 1;
                if (!en || wrap) begin
                    sh_d[u]  = (u == 1) ? digits : {16'h0, digits[15:0]};
                    sh_dp[u] = (u == 1) ? dpv : {4'h0, dpv[3:0]};
                    sh_bl[u] = (u == 1) ? blv : {4'h0, blv[3:0]};
                end
            end
        end
    end

    task automatic mcheck(input int u, input logic [7:0] an,
                          input logic [3:0] b, input logic d,
                          input logic [2:0] ix, input logic tk);
        int k;
        int n;
        bit lit;
        logic [7:0] nm;
        logic [7:0] ean;
        logic [3:0] eb;
        string p;
        n   = nd(u);
        k   = int'((ecnt[u] / longint'(dv(u))) % longint'(n));
        nm  = 8'((1 << n) - 1);
        lit = !rst && en && !sh_bl[u][k]
              && !(lzb && k > 0 && (sh_d[u] >> (4 * k)) == 0);
        ean = lit ? (~(8'd1 << k) & nm) : nm;
        eb  = lit ? 4'((sh_d[u] >> (4 * k)) & 32'hF) : 4'hF;
        p   = (u == 1) ? "b_" : "a_";
        chk({p, "idx"}, 64'(ix), 64'(k));
        chk({p, "anode"}, 64'(an), 64'(ean));
        chk({p, "bcd"}, 64'(b), 64'(eb));
        chk({p, "dp"}, 64'(d), 64'(lit && sh_dp[u][k]));
        chk({p, "tick"}, 64'(tk), 64'(mtick[u]));
    endtask

    always @(negedge clk) begin
        #3;
        if (mchk) begin
            mcheck(0, {4'h0, a_an}, a_bcd, a_dp, {1'b0, a_idx}, a_tick);
            mcheck(1, b_an, b_bcd, b_dp, b_idx, b_tick);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idx_a(input int k);
        int t = 0;
        while (a_idx != 2'(k) && t < 100) begin
            step();
            t++;
        end
        chk("wait_idx_a", 64'(a_idx), 64'(k));
    endtask

    task automatic wait_idx_b(input int k);
        int t = 0;
        while (b_idx != 3'(k) && t < 100) begin
            step();
            t++;
        end
        chk("wait_idx_b", 64'(b_idx), 64'(k));
    endtask

    task automatic wait_tick_a();
        int t = 0;
        step();
        while (!a_tick && t < 64) begin
            step();
            t++;
        end
        chk("wait_tick_a", 64'(a_tick), 64'(1));
    endtask

    task automatic wait_tick_b();
        int t = 0;
        step();
        while (!b_tick && t < 64) begin
            step();
            t++;
        end
        chk("wait_tick_b", 64'(b_tick), 64'(1));
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  bl;
        logic        lz;
        int          k;
        logic [3:0]  an;
        logic [3:0]  bcd;
        logic        dpo;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 4'h4, 1'b0};
        tbl[1]  = '{16'h1234, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 4'h1, 1'b0};
        tbl[2]  = '{16'h1234, 4'h2, 4'h4, 1'b0, 2, 4'b1111, 4'hF, 1'b0};
        tbl[3]  = '{16'h1234, 4'h2, 4'h4, 1'b0, 1, 4'b1101, 4'h3, 1'b1};
        tbl[4]  = '{16'h1234, 4'h2, 4'h4, 1'b0, 0, 4'b1110, 4'h4, 1'b0};
        tbl[5]  = '{16'h1234, 4'h2, 4'h4, 1'b0, 3, 4'b0111, 4'h1, 1'b0};
        tbl[6]  = '{16'h0040, 4'h0, 4'h0, 1'b1, 3, 4'b1111, 4'hF, 1'b0};
        tbl[7]  = '{16'h0040, 4'h0, 4'h0, 1'b1, 2, 4'b1111, 4'hF, 1'b0};
        tbl[8]  = '{16'h0040, 4'h0, 4'h0, 1'b1, 1, 4'b1101, 4'h4, 1'b0};
        tbl[9]  = '{16'h0040, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 4'h0, 1'b0};
        tbl[10] = '{16'h0000, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 4'h0, 1'b0};
        tbl[11] = '{16'h0000, 4'h1, 4'h0, 1'b1, 0, 4'b1110, 4'h0, 1'b1};
        tbl[12] = '{16'h0000, 4'h0, 4'h0, 1'b1, 1, 4'b1111, 4'hF, 1'b0};
        tbl[13] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 1, 4'b1101, 4'hC, 1'b0};
        tbl[14] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 4'hA, 1'b0};
        tbl[15] = '{16'h0040, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 4'h0, 1'b0};
        tbl[16] = '{16'h0040, 4'h0, 4'h1, 1'b1, 0, 4'b1111, 4'hF, 1'b0};

        rst = 1'b1; en = 1'b1; lzb = 1'b0;
        digits = '0; dpv = '0; blv = '0;

        // Reset held two cycles with en high
        step();
        chk("rst_a_anode", 64'(a_an), 64'(4'hF));
        chk("rst_a_bcd", 64'(a_bcd), 64'(4'hF));
        chk("rst_b_anode", 64'(b_an), 64'(8'hFF));
        mchk = 1'b1;
        step();
        chk("rst_a_dp", 64'(a_dp), 64'(0));
        rst = 1'b0;
        digits = 32'h0000_1234;
        step();
        chk("first_frame_idx", 64'(a_idx), 64'(0));
        chk("first_frame_bcd", 64'(a_bcd), 64'(0));
        chk("first_frame_an", 64'(a_an), 64'(4'b1110));
        wait_tick_a();
        chk("frame2_bcd0", 64'(a_bcd), 64'(4));
        begin
            int t = 0;
            step();
            t++;
            while (!a_tick && t < 40) begin
                step();
                t++;
            end
            chk("tick_period_a", 64'(t), 64'(16));
        end

        // Tear-free update
        wait_idx_a(2);
        digits = 32'h0000_5678;
        chk("tear_d2", 64'(a_bcd), 64'(2));
        wait_idx_a(3);
        chk("tear_d3", 64'(a_bcd), 64'(1));
        wait_idx_a(0);
        chk("tear_new_d0", 64'(a_bcd), 64'(8));
        wait_idx_a(1);
        chk("tear_new_d1", 64'(a_bcd), 64'(7));
        wait_idx_a(2);
        chk("tear_new_d2", 64'(a_bcd), 64'(6));
        wait_idx_a(3);
        chk("tear_new_d3", 64'(a_bcd), 64'(5));

        for (int i = 0; i < 17; i++) begin
            digits = {16'h0, tbl[i].d};
            dpv    = {4'h0, tbl[i].dp};
            blv    = {4'h0, tbl[i].bl};
            lzb    = tbl[i].lz;
            wait_tick_a();
            wait_idx_a(tbl[i].k);
            chk($sformatf("tbl%0d_an", i), 64'(a_an), 64'(tbl[i].an));
            chk($sformatf("tbl%0d_bcd", i), 64'(a_bcd), 64'(tbl[i].bcd));
            chk($sformatf("tbl%0d_dp", i), 64'(a_dp), 64'(tbl[i].dpo));
        end

        // Enable freeze at idx=1, cnt=2
        digits = 32'h0000_1234; dpv = '0; blv = '0; lzb = 1'b0;
        wait_tick_a();
        wait_idx_a(0);
        wait_idx_a(1);
        step();
        step();
        en = 1'b0;
        repeat (10) begin
            step();
            chk("frz_an", 64'(a_an), 64'(4'hF));
            chk("frz_bcd", 64'(a_bcd), 64'(4'hF));
            chk("frz_idx", 64'(a_idx), 64'(1));
        end
        en = 1'b1;
        #1;
        chk("reen_an0", 64'(a_an), 64'(4'b1101));
        step();
        chk("reen_an1", 64'(a_an), 64'(4'b1101));
        step();
        chk("reen_idx2", 64'(a_idx), 64'(2));
        chk("reen_an2", 64'(a_an), 64'(4'b1011));

        // Fast mode on the 8-digit instance
        digits = 32'h89AB_CDEF;
        wait_tick_b();
        begin
            logic [31:0] cst;
            cst = 32'h89AB_CDEF;
            for (int i = 0; i < 16; i++) begin
                chk("fast_idx", 64'(b_idx), 64'(i % 8));
                chk("fast_bcd", 64'(b_bcd), 64'((cst >> (4 * (i % 8))) & 32'hF));
                chk("fast_tick", 64'(b_tick), 64'(i % 8 == 0));
                step();
            end
        end
        wait_idx_b(5);
        rst = 1'b1;
        #1;
        chk("mid_rst_b_an", 64'(b_an), 64'(8'hFF));
        chk("mid_rst_b_bcd", 64'(b_bcd), 64'(4'hF));
        step();
        chk("mid_rst_b_idx", 64'(b_idx), 64'(0));
        chk("mid_rst_a_idx", 64'(a_idx), 64'(0));
        step();
        chk("mid_rst_b_an2", 64'(b_an), 64'(8'hFF));
        rst = 1'b0;
        step();
        chk("post_rst_b_idx", 64'(b_idx), 64'(1));

        // Random traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            en     = ($urandom_range(0, 9) != 0);
            lzb    = $urandom_range(0, 1) == 1;
            digits = $urandom >> $urandom_range(0, 32);
            dpv    = 8'($urandom);
            blv    = 8'($urandom & $urandom & $urandom);
            step();
        end
        rst = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
